// File: rtl/pool_pkg.sv
// Pooling engine shared types and constants.
// Mode encodings, FSM state enum and sizing helpers.
`timescale 1ns/1ps
package pool_pkg;

  localparam logic [1:0] MODE_MAX = 2'b00;
  localparam logic [1:0] MODE_AVG = 2'b01;
  localparam logic [1:0] MODE_MIN = 2'b10;
  localparam logic [1:0] MODE_SUM = 2'b11;

  localparam int DEF_RAM_WIDTH = 512;
  localparam int DEF_ELEM_W    = 32;
  localparam int DEF_GROUP     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_REDUCE,
    ST_WR_REQ,
    ST_DONE
  } state_t;

  // log2 of the group size, 0 for a group of one
  function automatic int glog(input int g);
    return (g > 1) ? $clog2(g) : 0;
  endfunction

endpackage

// File: rtl/pool_reduce.sv
// One GROUP-lane reducer: max/min/avg/sum, shift, saturate.
// Single registered stage, loaded when en is high.
`timescale 1ns/1ps
module pool_reduce
  import pool_pkg::*;
#(
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int GROUP  = DEF_GROUP
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [3:0]                shift,
  input  logic [ELEM_W*GROUP-1:0]   lanes,
  output logic [ELEM_W-1:0]         res
);

  localparam int GL = glog(GROUP);
  localparam int SW = ELEM_W + GL;

  logic signed [ELEM_W-1:0] w_lane;
  logic signed [SW-1:0]     w_ext;
  logic signed [SW-1:0]     w_sum;
  logic signed [SW-1:0]     w_max;
  logic signed [SW-1:0]     w_min;
  logic signed [SW-1:0]     w_pre;
  logic signed [SW-1:0]     w_sh;
  logic [5:0]               w_amt;
  logic [GL:0]              w_top;
  logic [ELEM_W-1:0]        w_sat;

  // combinational reduce, shift and clamp to ELEM_W
  always_comb begin
    w_lane = '0;
    w_ext  = '0;
    w_sum  = '0;
    w_max  = '0;
    w_min  = '0;
    for (int j = 0; j < GROUP; j++) begin
      w_lane = lanes[j*ELEM_W +: ELEM_W];
      w_ext  = SW'(w_lane);
      w_sum  = w_sum + w_ext;
      if (j == 0 || w_ext > w_max) w_max = w_ext;
      if (j == 0 || w_ext < w_min) w_min = w_ext;
    end
    unique case (mode)
      MODE_MAX: w_pre = w_max;
      MODE_MIN: w_pre = w_min;
      MODE_AVG: w_pre = w_sum;
      MODE_SUM: w_pre = w_sum;
    endcase
    w_amt = (mode == MODE_AVG) ? 6'(GL) + 6'(shift) : 6'(shift);
    w_sh  = w_pre >>> w_amt;
    w_top = w_sh[SW-1:ELEM_W-1];
    if (&w_top || ~|w_top)
      w_sat = w_sh[ELEM_W-1:0];
    else if (w_top[GL])
      w_sat = {1'b1, {(ELEM_W-1){1'b0}}};
    else
      w_sat = {1'b0, {(ELEM_W-1){1'b1}}};
  end

  // result register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   res <= '0;
    else if (en) res <= w_sat;
  end

endmodule

// File: rtl/pool_engine_v2.sv
// Pooling engine bus master: read, reduce, pack, write back in place.
// One job per req_i; ack_o pulses when the job is done.
`timescale 1ns/1ps
module pool_engine_v2
  import pool_pkg::*;
#(
  parameter int                   RAM_WIDTH  = DEF_RAM_WIDTH,
  parameter int                   ELEM_W     = DEF_ELEM_W,
  parameter int                   GROUP      = DEF_GROUP,
  parameter int                   NUM_MEM    = 5,
  parameter logic [64*NUM_MEM-1:0] ADDR_TABLE = {NUM_MEM{64'h0}},
  parameter int                   HEIGHT_W   = 9
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [2:0]             select_i,
  input  logic [1:0]             mode_i,
  input  logic [3:0]             shift_i,
  input  logic [HEIGHT_W-1:0]    height_i,
  input  logic                   req_i,
  output logic                   ack_o,
  output logic                   err_o,
  output logic [63:0]            addr_o,
  output logic                   read_o,
  output logic                   write_o,
  output logic [RAM_WIDTH/8-1:0] byteenable_o,
  output logic [RAM_WIDTH-1:0]   writedata_o,
  input  logic [RAM_WIDTH-1:0]   readdata_i,
  input  logic                   readdatavalid_i,
  input  logic                   waitreq_i,
  output logic                   lock_o
);

  localparam int GL   = glog(GROUP);
  localparam int CW   = (GL > 0) ? GL : 1;
  localparam int NRED = RAM_WIDTH / (ELEM_W * GROUP);
  localparam int SW   = RAM_WIDTH / GROUP;
  localparam int BW   = SW / 8;
  localparam int NB   = RAM_WIDTH / 8;

  state_t                r_state;
  logic [1:0]            r_mode;
  logic [3:0]            r_shift;
  logic [HEIGHT_W-1:0]   r_remain;
  logic [63:0]           r_rd_ptr;
  logic [63:0]           r_wr_ptr;
  logic [CW-1:0]         r_cnt;
  logic [GROUP-1:0]      r_vld;
  logic [RAM_WIDTH-1:0]  r_pack;

  logic                  w_cap;
  logic                  w_bad;
  logic [63:0]           w_base;
  logic [SW-1:0]         w_red;
  logic [RAM_WIDTH-1:0]  w_pack;
  logic [GROUP-1:0]      w_vld;
  logic [NB-1:0]         w_be;
  logic                  w_last;

  assign w_cap  = (r_state == ST_RD_WAIT) && readdatavalid_i;
  assign w_bad  = int'(select_i) >= NUM_MEM;
  assign w_last = (r_cnt == CW'(GROUP-1)) || (r_remain == '0);

  // region base lookup
  always_comb begin
    w_base = '0;
    for (int k = 0; k < NUM_MEM; k++)
      if (int'(select_i) == k) w_base = ADDR_TABLE[k*64 +: 64];
  end

  for (genvar g = 0; g < NRED; g++) begin : g_red
    pool_reduce #(
      .ELEM_W (ELEM_W),
      .GROUP  (GROUP)
    ) u_red (
      .clk   (clk),
      .rstn  (rstn),
      .en    (w_cap),
      .mode  (r_mode),
      .shift (r_shift),
      .lanes (readdata_i[g*ELEM_W*GROUP +: ELEM_W*GROUP]),
      .res   (w_red[g*ELEM_W +: ELEM_W])
    );
  end

  // pack buffer with the current reduced slice merged in
  always_comb begin
    w_pack = r_pack;
    w_vld  = r_vld;
    w_pack[r_cnt*SW +: SW] = w_red;
    w_vld[r_cnt] = 1'b1;
    w_be = '0;
    for (int g = 0; g < GROUP; g++)
      w_be[g*BW +: BW] = {BW{w_vld[g]}};
  end

  // job FSM with registered bus outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_mode       <= '0;
      r_shift      <= '0;
      r_remain     <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_cnt        <= '0;
      r_vld        <= '0;
      r_pack       <= '0;
      ack_o        <= 1'b0;
      err_o        <= 1'b0;
      addr_o       <= '0;
      read_o       <= 1'b0;
      write_o      <= 1'b0;
      byteenable_o <= '0;
      writedata_o  <= '0;
      lock_o       <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (req_i) begin
            r_mode   <= mode_i;
            r_shift  <= shift_i;
            r_remain <= height_i;
            r_rd_ptr <= w_base;
            r_wr_ptr <= w_base;
            r_cnt    <= '0;
            r_vld    <= '0;
            r_pack   <= '0;
            if (w_bad || height_i == '0) begin
              ack_o   <= 1'b1;
              err_o   <= w_bad;
              lock_o  <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              lock_o  <= 1'b1;
              read_o  <= 1'b1;
              addr_o  <= w_base;
              r_state <= ST_RD_REQ;
            end
          end
        end
        ST_RD_REQ: begin
          if (!waitreq_i) begin
            read_o   <= 1'b0;
            r_rd_ptr <= r_rd_ptr + 64'd1;
            r_state  <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (readdatavalid_i) begin
            r_remain <= r_remain - 1'b1;
            r_state  <= ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          r_pack <= w_pack;
          r_vld  <= w_vld;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            write_o      <= 1'b1;
            addr_o       <= r_wr_ptr;
            writedata_o  <= w_pack;
            byteenable_o <= w_be;
            r_state      <= ST_WR_REQ;
          end else begin
            read_o  <= 1'b1;
            addr_o  <= r_rd_ptr;
            r_state <= ST_RD_REQ;
          end
        end
        ST_WR_REQ: begin
          if (!waitreq_i) begin
            write_o      <= 1'b0;
            writedata_o  <= '0;
            byteenable_o <= '0;
            r_wr_ptr     <= r_wr_ptr + 64'd1;
            r_pack       <= '0;
            r_vld        <= '0;
            r_cnt        <= '0;
            if (r_remain == '0) begin
              ack_o   <= 1'b1;
              lock_o  <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              read_o  <= 1'b1;
              addr_o  <= r_rd_ptr;
              r_state <= ST_RD_REQ;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_engine_v2.sv
// Directed bench for pool_engine_v2 with a small bus responder.
// Expected results are hand-computed constants.
`timescale 1ns/1ps
module tb_pool_engine_v2;

  localparam logic [63:0] B0 = 64'h0000_00A0_0000_0100;
  localparam logic [63:0] B1 = 64'h0000_00A0_0000_0200;
  localparam logic [63:0] B2 = 64'h0000_00A0_0000_0300;
  localparam logic [63:0] B3 = 64'h0000_00A0_0000_0400;
  localparam logic [63:0] B4 = 64'h0000_00A0_0000_0500;
  localparam logic [319:0] TBL = {B4, B3, B2, B1, B0};
  localparam logic [63:0] BE_ALL = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] BE_S0  = 64'h0000_0000_0000_FFFF;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [2:0]   select_i = '0;
  logic [1:0]   mode_i = '0;
  logic [3:0]   shift_i = '0;
  logic [8:0]   height_i = '0;
  logic         req_i = 1'b0;
  logic         ack_o, err_o, read_o, write_o, lock_o;
  logic [63:0]  addr_o;
  logic [63:0]  byteenable_o;
  logic [511:0] writedata_o;
  logic [511:0] readdata_i = '0;
  logic         readdatavalid_i = 1'b0;
  logic         waitreq_i = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [511:0] mem [16];
  int           stall_n = 0;
  int           n_rd = 0;
  int           n_wr = 0;
  logic [63:0]  wq_a [$];
  logic [511:0] wq_d [$];
  logic [63:0]  wq_b [$];

  logic         busy = 1'b0;
  int           left = 0;
  logic         pend = 1'b0;
  logic [3:0]   pend_idx = '0;
  logic [641:0] hold = '0;

  pool_engine_v2 #(
    .RAM_WIDTH  (512),
    .ELEM_W     (32),
    .GROUP      (4),
    .NUM_MEM    (5),
    .ADDR_TABLE (TBL),
    .HEIGHT_W   (9)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .select_i        (select_i),
    .mode_i          (mode_i),
    .shift_i         (shift_i),
    .height_i        (height_i),
    .req_i           (req_i),
    .ack_o           (ack_o),
    .err_o           (err_o),
    .addr_o          (addr_o),
    .read_o          (read_o),
    .write_o         (write_o),
    .byteenable_o    (byteenable_o),
    .writedata_o     (writedata_o),
    .readdata_i      (readdata_i),
    .readdatavalid_i (readdatavalid_i),
    .waitreq_i       (waitreq_i),
    .lock_o          (lock_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [639:0] obs,
                     input logic [639:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk(input int a, input int b,
                                      input int c, input int d);
    logic [31:0]  p [4];
    logic [511:0] w;
    p[0] = a; p[1] = b; p[2] = c; p[3] = d;
    w = '0;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = p[i%4];
    return w;
  endfunction

  function automatic logic [127:0] sl(input int v);
    logic [31:0] t;
    t = v;
    return {4{t}};
  endfunction

  // bus slave: stalls, returns read data one cycle after accept, logs writes
  always @(negedge clk) begin
    if (!rstn) begin
      busy = 1'b0;
      pend = 1'b0;
      left = 0;
      readdatavalid_i = 1'b0;
      waitreq_i = 1'b0;
    end else begin
      readdatavalid_i = 1'b0;
      if (pend) begin
        readdatavalid_i = 1'b1;
        readdata_i = mem[pend_idx];
        pend = 1'b0;
      end
      if (busy) begin
        checks++;
        assert ({read_o, write_o, addr_o, writedata_o, byteenable_o} === hold)
        else begin
          errors++;
          $error("FAIL stall_hold: observed %0h expected %0h",
                 {read_o, write_o, addr_o, writedata_o, byteenable_o}, hold);
        end
      end
      if (read_o || write_o) begin
        if (!busy) begin
          busy = 1'b1;
          left = stall_n;
          hold = {read_o, write_o, addr_o, writedata_o, byteenable_o};
        end
        if (left > 0) begin
          waitreq_i = 1'b1;
          left--;
        end else begin
          waitreq_i = 1'b0;
          busy = 1'b0;
          if (read_o) begin
            pend = 1'b1;
            pend_idx = addr_o[3:0];
            n_rd++;
          end else begin
            n_wr++;
            wq_a.push_back(addr_o);
            wq_d.push_back(writedata_o);
            wq_b.push_back(byteenable_o);
          end
        end
      end else begin
        waitreq_i = 1'b0;
      end
    end
  end

  task automatic run_job(input logic [2:0] sel, input logic [1:0] md,
                         input logic [3:0] sh, input logic [8:0] h,
                         output logic e, output int lat, output logic lk);
    n_rd = 0;
    n_wr = 0;
    wq_a.delete();
    wq_d.delete();
    wq_b.delete();
    @(negedge clk);
    select_i = sel;
    mode_i = md;
    shift_i = sh;
    height_i = h;
    req_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
    lk = lock_o;
    lat = 1;
    while (!ack_o && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    chk("ack_seen", 640'(ack_o), 640'(1'b1));
    e = err_o;
    @(negedge clk);
    chk("ack_pulse", 640'(ack_o), 640'(1'b0));
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [63:0] a,
                        input logic [511:0] d, input logic [63:0] b);
    chk({tag, "_addr"}, 640'(wq_a[i]), 640'(a));
    chk({tag, "_data"}, 640'(wq_d[i]), 640'(d));
    chk({tag, "_be"}, 640'(wq_b[i]), 640'(b));
  endtask

  initial begin
    logic e;
    int   lat;
    logic lk;
    logic seen;
    int   i;

    repeat (3) @(negedge clk);
    chk("reset_outs",
        640'({ack_o, err_o, addr_o, read_o, write_o, byteenable_o,
              writedata_o, lock_o}), 640'(0));
    rstn = 1'b1;

    // max, 4 words, one full write
    for (int k = 0; k < 4; k++) mem[k] = mk(1, -7, 5, 3);
    run_job(3'd1, 2'b00, 4'd0, 9'd4, e, lat, lk);
    chk("max_lock", 640'(lk), 640'(1'b1));
    chk("max_err", 640'(e), 640'(1'b0));
    chk("max_nrd", 640'(n_rd), 640'(4));
    chk("max_nwr", 640'(n_wr), 640'(1));
    chk_wr("max", 0, B1, {sl(5), sl(5), sl(5), sl(5)}, BE_ALL);

    // avg, single word, slot 0 only
    mem[0] = mk(4, 4, 4, 5);
    run_job(3'd0, 2'b01, 4'd0, 9'd1, e, lat, lk);
    chk("avg_nwr", 640'(n_wr), 640'(1));
    chk_wr("avg_pos", 0, B0, {384'h0, sl(4)}, BE_S0);
    mem[0] = mk(-1, -1, -1, -2);
    run_job(3'd0, 2'b01, 4'd0, 9'd1, e, lat, lk);
    chk_wr("avg_neg", 0, B0, {384'h0, sl(-2)}, BE_S0);

    // sum saturation both ways
    mem[0] = mk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_job(3'd3, 2'b11, 4'd0, 9'd1, e, lat, lk);
    chk_wr("sum_satp", 0, B3, {384'h0, sl(32'h7FFF_FFFF)}, BE_S0);
    mem[0] = mk(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    run_job(3'd3, 2'b11, 4'd0, 9'd1, e, lat, lk);
    chk_wr("sum_satn", 0, B3, {384'h0, sl(32'h8000_0000)}, BE_S0);

    // shifted sum and shifted min
    mem[0] = mk(10, 20, 30, 40);
    run_job(3'd4, 2'b11, 4'd2, 9'd1, e, lat, lk);
    chk_wr("sum_sh", 0, B4, {384'h0, sl(25)}, BE_S0);
    mem[0] = mk(1, -7, 5, 3);
    run_job(3'd2, 2'b10, 4'd1, 9'd1, e, lat, lk);
    chk_wr("min_sh", 0, B2, {384'h0, sl(-4)}, BE_S0);

    // stalled rerun of the max job
    stall_n = 5;
    for (int k = 0; k < 4; k++) mem[k] = mk(1, -7, 5, 3);
    run_job(3'd1, 2'b00, 4'd0, 9'd4, e, lat, lk);
    chk("stl_nrd", 640'(n_rd), 640'(4));
    chk("stl_nwr", 640'(n_wr), 640'(1));
    chk_wr("stl", 0, B1, {sl(5), sl(5), sl(5), sl(5)}, BE_ALL);
    stall_n = 0;

    // zero height and bad select
    run_job(3'd1, 2'b00, 4'd0, 9'd0, e, lat, lk);
    chk("h0_err", 640'(e), 640'(1'b0));
    chk("h0_lat", 640'(lat <= 2), 640'(1'b1));
    chk("h0_traffic", 640'(n_rd + n_wr), 640'(0));
    run_job(3'd7, 2'b00, 4'd0, 9'd4, e, lat, lk);
    chk("sel7_err", 640'(e), 640'(1'b1));
    chk("sel7_traffic", 640'(n_rd + n_wr), 640'(0));

    // reset during a stalled write
    stall_n = 5;
    for (int k = 0; k < 4; k++) mem[k] = mk(1, -7, 5, 3);
    @(negedge clk);
    select_i = 3'd1;
    mode_i = 2'b00;
    shift_i = 4'd0;
    height_i = 9'd4;
    req_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
    i = 0;
    while (!write_o && i < 500) begin
      @(negedge clk);
      i++;
    end
    chk("rst_reach_wr", 640'(write_o), 640'(1'b1));
    #2 rstn = 1'b0;
    #1;
    chk("rst_outs",
        640'({ack_o, err_o, addr_o, read_o, write_o, byteenable_o,
              writedata_o, lock_o}), 640'(0));
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | ack_o;
    end
    chk("rst_no_ack", 640'(seen), 640'(1'b0));
    rstn = 1'b1;
    stall_n = 0;

    // height 5 after reset: full write then slot 0 only
    mem[0] = mk(1, 2, 3, 4);
    mem[1] = mk(-5, -6, -7, -8);
    mem[2] = mk(100, 0, 0, 0);
    mem[3] = mk(0, 0, 0, -1);
    mem[4] = mk(9, 9, 9, 9);
    run_job(3'd2, 2'b00, 4'd0, 9'd5, e, lat, lk);
    chk("h5_nrd", 640'(n_rd), 640'(5));
    chk("h5_nwr", 640'(n_wr), 640'(2));
    chk_wr("h5_w0", 0, B2, {sl(0), sl(100), sl(-5), sl(4)}, BE_ALL);
    chk_wr("h5_w1", 1, B2 + 64'd1, {384'h0, sl(9)}, BE_S0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
